apb_master_bridge: RTL
======================

# apb_master_bridge

APB requester that turns a simple valid/ready request port into single APB3 transfers (SETUP → ACCESS) and returns a one-cycle response pulse with read data and error. It sits between an internal initiator (core load/store unit or debug port) and the peripheral APB segment that hosts the UART and similar APB responders. It drives the requester side of the interface those responders implement. A programmable access timeout prevents a hung or unmapped responder from stalling the initiator.

## Interface
- ADDR_WIDTH, 12, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without pready before an abort; 0 disables the timeout
- pclk_i  in  1  clock; all logic is rising-edge
- prst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  bridge idle, can accept a request
- req_addr_i  in  ADDR_WIDTH  request address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  DATA_WIDTH  read data; valid when rsp_valid_o = 1
- rsp_err_o  out  1  pslverr or timeout; valid when rsp_valid_o = 1
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  DATA_WIDTH  APB write data
- prdata_i  in  DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: req_ready_o = 1 (combinational decode of state == IDLE), psel_o = 0, penable_o = 0. When req_valid_i && req_ready_o: capture addr, write, and wdata; go to SETUP.
- SETUP: psel_o = 1, penable_o = 0, timeout counter cleared. The next state is unconditionally ACCESS. pready_i is ignored in SETUP.
- ACCESS: psel_o = 1, penable_o = 1.
  - pready_i = 1: complete the transfer and go to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES (if nonzero), abort and go to IDLE.
- paddr_o, pwrite_o and pwdata_o come from the capture registers. They are stable from SETUP through the final ACCESS cycle. pwdata_o = 0 for reads.
- Completion (registered, visible on the cycle after the pready or abort edge):
  - rsp_valid_o = 1 for exactly one cycle.
  - rsp_err_o = pslverr_i sampled with pready_i, or 1 on timeout.
  - rsp_rdata_o = prdata_i for read completions, including pslverr completions. rsp_rdata_o = 0 for writes and timeouts.
  - rsp_rdata_o and rsp_err_o hold until the next completion.
- Responses have no backpressure; the initiator must take rsp_valid_o when it is asserted.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Reset (async): state goes to IDLE and all registered outputs go to 0. req_ready_o = 1 while in IDLE, including during reset. A transfer in flight is dropped: psel_o and penable_o fall immediately and no response is issued.

## Timing
- Accept at edge T (req_valid_i and req_ready_o both high in the cycle before T).
- SETUP occupies cycle T..T+1; ACCESS starts at T+1.
- With pready_i = 1 on the first ACCESS cycle:
  - rsp_valid_o is high in cycle T+2..T+3.
  - req_ready_o is high in that same cycle.
- Each wait state adds one cycle.
- Peak throughput: one transfer per 3 cycles. A new request may be accepted in the same cycle rsp_valid_o is high.
- Timeout with TIMEOUT_CYCLES = N: the abort occurs after N ACCESS cycles with pready_i low. rsp_valid_o follows one cycle later.
- If pready_i rises on the same edge the counter reaches N, pready_i wins: normal completion, with the error taken from pslverr_i.
- Request inputs are sampled only on the accept edge. Changes while busy are ignored.

## Test plan
- Write, pready_i tied 1:
  - Stimulus: addr 0x010, wdata 0xA5A5_0001.
  - Response: psel_o high 2 cycles, penable_o high 1 cycle, paddr_o/pwdata_o stable. rsp_valid_o pulses 3 cycles after accept with rsp_err_o = 0 and rsp_rdata_o = 0.
- Read, 2 wait states:
  - Stimulus: addr 0x004, prdata_i = 0x0000_00C3 with pready_i.
  - Response: ACCESS lasts 3 cycles. rsp_valid_o pulses 5 cycles after accept, with rsp_rdata_o = 0x0000_00C3 and rsp_err_o = 0.
- Slave error:
  - Stimulus: read with pready_i = 1, pslverr_i = 1, prdata_i = 0xDEAD_BEEF.
  - Response: rsp_err_o = 1, rsp_rdata_o = 0xDEAD_BEEF.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, pready_i held 0.
  - Response: psel_o/penable_o drop after 4 ACCESS cycles; then rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0, and the FSM returns to IDLE.
  - Repeat with pready_i rising on the 4th ACCESS cycle: rsp_err_o = 0.
- Back-to-back:
  - Stimulus: req_valid_i held 1 for 3 writes, pready_i = 1.
  - Response: accepts every 3 cycles; exactly 3 rsp_valid_o pulses; paddr_o sequence matches request order.
- Reset mid-ACCESS:
  - Stimulus: assert prst_ni = 0 during a wait state.
  - Response: psel_o, penable_o and rsp_valid_o go to 0 immediately and req_ready_o = 1. After release, the next request completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready request into one APB3 transfer
// (SETUP -> ACCESS) and returns a one-cycle response pulse. An ACCESS-phase
// timeout aborts transfers to hung or unmapped responders.
//
// Ports
//   pclk_i, prst_ni          clock, async active-low reset
//   req_valid_i/req_ready_o  request handshake; ready while idle
//   req_addr_i/_write_i/_wdata_i  request payload, sampled on accept
//   rsp_valid_o              one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o   completion data/error, held until next completion
//   psel_o .. pwdata_o       APB requester outputs
//   prdata_i, pready_i, pslverr_i  APB responder inputs
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk_i,
  input  logic                  prst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  // A zero timeout still needs a 1-bit counter to keep the logic legal.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Abort fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_c, abort_c;
  logic             accept_c;

  // Status decodes of the state register.
  assign req_ready_o = (state_q == IDLE);
  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign accept_c    = req_valid_i && req_ready_o;

  // State and timeout counter registers.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, completion/abort decode and saturating timeout count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) state_d = SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          // pready wins over a timeout landing on the same edge
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; write data is zeroed for reads so pwdata_o is clean.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
    end else if (accept_c) begin
      paddr_o  <= req_addr_i;
      pwrite_o <= req_write_i;
      pwdata_o <= req_write_i ? req_wdata_i : '0;
    end
  end

  // Response pulse; data and error hold until the next completion.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= done_c || abort_c;
      if (done_c) begin
        rsp_err_o   <= pslverr_i;
        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
      end else if (abort_c) begin
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= '0;
      end
    end
  end

endmodule
